fc_layer_engine: RTL

- Parametrised next-generation fully-connected data mover and compute engine.
- Streams input nodes and packed weights from BRAM into NUM_CORE MAC lanes, each lane computing one output neuron, and preloads each lane accumulator with its bias.
- Accumulates over a run-time input count, applies optional ReLU, and writes the packed result vector back to a result BRAM.
- Sits between the AXI-lite control registers (run/length/base/mode) and the node, weight, bias and result BRAMs.

---
 rtl/fc_pkg.sv | 44 ++++
 rtl/fc_mac_lane.sv | 54 +++++
 rtl/fc_layer_engine.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/fc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fc_pkg
//  Description : Shared state/tag encodings and default widths for the
//                fully-connected layer engine.
//  Revision    : 1.0 - initial release
// ============================================================================
package fc_pkg;

    localparam int C_NUM_CORE = 8;
    localparam int C_IN_DW    = 8;
    localparam int C_ACC_DW   = 32;
    localparam int C_AWIDTH   = 12;
    localparam int C_CNT_BIT  = 16;
    localparam int C_RD_LAT   = 1;

    localparam logic [2:0] C_ST_IDLE  = 3'd0;
    localparam logic [2:0] C_ST_BIAS  = 3'd1;
    localparam logic [2:0] C_ST_RUN   = 3'd2;
    localparam logic [2:0] C_ST_DRAIN = 3'd3;
    localparam logic [2:0] C_ST_WRITE = 3'd4;
    localparam logic [2:0] C_ST_DONE  = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE  = C_ST_IDLE,
        ST_BIAS  = C_ST_BIAS,
        ST_RUN   = C_ST_RUN,
        ST_DRAIN = C_ST_DRAIN,
        ST_WRITE = C_ST_WRITE,
        ST_DONE  = C_ST_DONE
    } state_t;

    localparam logic [1:0] C_TAG_NONE = 2'd0;
    localparam logic [1:0] C_TAG_BIAS = 2'd1;
    localparam logic [1:0] C_TAG_DATA = 2'd2;

    typedef enum logic [1:0] {
        TAG_NONE = C_TAG_NONE,
        TAG_BIAS = C_TAG_BIAS,
        TAG_DATA = C_TAG_DATA
    } tag_t;

endpackage
`default_nettype wire

// File: rtl/fc_mac_lane.sv
`default_nettype none
// ============================================================================
//  Module      : fc_mac_lane
//  Description : One output neuron: bias preload, unsigned-node x signed-weight
//                multiply-accumulate (modular), optional ReLU on the result.
//  Revision    : 1.0 - initial release
// ============================================================================
module fc_mac_lane #(
    parameter int IN_DW  = 8,
    parameter int ACC_DW = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              load_bias,
    input  logic              acc_en,
    input  logic [IN_DW-1:0]  node,
    input  logic [IN_DW-1:0]  wegt,
    input  logic [IN_DW-1:0]  bias,
    input  logic              relu,
    output logic [ACC_DW-1:0] result
);

    logic [2*IN_DW:0]  w_node_x;
    logic [2*IN_DW:0]  w_wegt_x;
    logic [2*IN_DW:0]  w_prod;
    logic [ACC_DW-1:0] w_prod_ext;
    logic [ACC_DW-1:0] w_bias_ext;
    logic [ACC_DW-1:0] r_acc;

    // Both operands widened to the full product width so the truncated
    // two's-complement multiply yields the exact signed product.
    assign w_node_x   = {{(IN_DW+1){1'b0}}, node};
    assign w_wegt_x   = {{(IN_DW+1){wegt[IN_DW-1]}}, wegt};
    assign w_prod     = w_node_x * w_wegt_x;
    assign w_prod_ext = {{(ACC_DW-2*IN_DW-1){w_prod[2*IN_DW]}}, w_prod};
    assign w_bias_ext = {{(ACC_DW-IN_DW){bias[IN_DW-1]}}, bias};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_acc <= '0;
        end else if (clear) begin
            r_acc <= '0;
        end else if (load_bias) begin
            r_acc <= w_bias_ext;
        end else if (acc_en) begin
            r_acc <= r_acc + w_prod_ext;
        end
    end

    assign result = (relu && r_acc[ACC_DW-1]) ? '0 : r_acc;

endmodule
`default_nettype wire

// File: rtl/fc_layer_engine.sv
`default_nettype none
// ============================================================================
//  Module      : fc_layer_engine
//  Description : FSM, read sequencing, read-valid tag pipeline and BRAM
//                interface feeding NUM_CORE MAC lanes of a dense layer.
//  Revision    : 1.0 - initial release
// ============================================================================
module fc_layer_engine
    import fc_pkg::*;
#(
    parameter int NUM_CORE = C_NUM_CORE,
    parameter int IN_DW    = C_IN_DW,
    parameter int ACC_DW   = C_ACC_DW,
    parameter int AWIDTH   = C_AWIDTH,
    parameter int CNT_BIT  = C_CNT_BIT,
    parameter int RD_LAT   = C_RD_LAT
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       i_run,
    input  logic [CNT_BIT-1:0]         i_num_in,
    input  logic [AWIDTH-1:0]          i_w_base,
    input  logic [AWIDTH-1:0]          i_out_addr,
    input  logic                       i_relu,
    output logic                       o_idle,
    output logic                       o_busy,
    output logic                       o_done,
    output logic [AWIDTH-1:0]          addr_n,
    output logic                       ce_n,
    input  logic [IN_DW-1:0]           q_n,
    output logic [AWIDTH-1:0]          addr_w,
    output logic                       ce_w,
    input  logic [NUM_CORE*IN_DW-1:0]  q_w,
    output logic [AWIDTH-1:0]          addr_b,
    output logic                       ce_b,
    input  logic [NUM_CORE*IN_DW-1:0]  q_b,
    output logic [AWIDTH-1:0]          addr_r,
    output logic                       ce_r,
    output logic                       we_r,
    output logic [NUM_CORE*ACC_DW-1:0] d_r,
    output logic [NUM_CORE*ACC_DW-1:0] o_result
);

    localparam logic [CNT_BIT-1:0] C_ONE        = CNT_BIT'(1);
    localparam logic [CNT_BIT-1:0] C_DRAIN_INIT = CNT_BIT'(RD_LAT - 1);

    state_t                     r_state;
    state_t                     w_next;
    tag_t                       w_issue;
    tag_t                       r_tag [RD_LAT];
    tag_t                       w_ret_tag;
    logic [CNT_BIT-1:0]         r_cnt;
    logic [CNT_BIT-1:0]         r_num;
    logic [AWIDTH-1:0]          r_w_base;
    logic [AWIDTH-1:0]          r_out_addr;
    logic                       r_relu;
    logic [AWIDTH-1:0]          w_k;
    logic                       w_run_last;
    logic                       w_start;
    logic [NUM_CORE*ACC_DW-1:0] w_results;

    assign w_k        = AWIDTH'(r_cnt);
    assign w_run_last = (r_cnt == (r_num - C_ONE));
    assign w_start    = (r_state == ST_IDLE) && i_run;
    assign w_ret_tag  = r_tag[RD_LAT-1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_issue = TAG_NONE;
        ce_n    = 1'b0;
        ce_w    = 1'b0;
        ce_b    = 1'b0;
        ce_r    = 1'b0;
        we_r    = 1'b0;
        addr_n  = '0;
        addr_w  = '0;
        addr_b  = '0;
        addr_r  = '0;
        o_idle  = 1'b0;
        o_busy  = 1'b1;
        o_done  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                o_idle = 1'b1;
                o_busy = 1'b0;
                if (i_run) w_next = ST_BIAS;
            end
            ST_BIAS: begin
                ce_b    = 1'b1;
                addr_b  = r_out_addr;
                w_issue = TAG_BIAS;
                w_next  = (r_num == '0) ? ST_DRAIN : ST_RUN;
            end
            ST_RUN: begin
                ce_n    = 1'b1;
                ce_w    = 1'b1;
                addr_n  = w_k;
                addr_w  = r_w_base + w_k;
                w_issue = TAG_DATA;
                if (w_run_last) w_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (r_cnt == '0) w_next = ST_WRITE;
            end
            ST_WRITE: begin
                ce_r   = 1'b1;
                we_r   = 1'b1;
                addr_r = r_out_addr;
                w_next = ST_DONE;
            end
            ST_DONE: begin
                o_busy = 1'b0;
                o_done = 1'b1;
                w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // r_cnt is the read index k in RUN and the drain down-counter in DRAIN.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt      <= '0;
            r_num      <= '0;
            r_w_base   <= '0;
            r_out_addr <= '0;
            r_relu     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                    if (i_run) begin
                        r_num      <= i_num_in;
                        r_w_base   <= i_w_base;
                        r_out_addr <= i_out_addr;
                        r_relu     <= i_relu;
                    end
                end
                ST_BIAS:  r_cnt <= (r_num == '0) ? C_DRAIN_INIT : '0;
                ST_RUN:   r_cnt <= w_run_last ? C_DRAIN_INIT : (r_cnt + C_ONE);
                ST_DRAIN: if (r_cnt != '0) r_cnt <= r_cnt - C_ONE;
                default:  r_cnt <= '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < RD_LAT; i++) r_tag[i] <= TAG_NONE;
        end else begin
            r_tag[0] <= w_issue;
            for (int i = 1; i < RD_LAT; i++) r_tag[i] <= r_tag[i-1];
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_CORE; gi++) begin : g_lane
            fc_mac_lane #(
                .IN_DW  (IN_DW),
                .ACC_DW (ACC_DW)
            ) u_lane (
                .clk       (clk),
                .reset_n   (reset_n),
                .clear     (w_start),
                .load_bias (w_ret_tag == TAG_BIAS),
                .acc_en    (w_ret_tag == TAG_DATA),
                .node      (q_n),
                .wegt      (q_w[gi*IN_DW +: IN_DW]),
                .bias      (q_b[gi*IN_DW +: IN_DW]),
                .relu      (r_relu),
                .result    (w_results[gi*ACC_DW +: ACC_DW])
            );
        end
    endgenerate

    assign d_r = (r_state == ST_WRITE) ? w_results : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            o_result <= '0;
        end else if (r_state == ST_WRITE) begin
            o_result <= w_results;
        end
    end

endmodule
`default_nettype wire
